// File: rtl/axi_4_mst.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// Optional watchdog on every wait state: define AXI_MST_TIMEOUT_EN.

`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH 4
`endif

module axi_4_mst #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_wr,
    input  logic [`C_AXI_ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [`C_AXI_DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [`C_AXI_STROBE_WIDTH-1:0]  cmd_wstrb,
    output logic                            rsp_valid,
    output logic [`C_AXI_DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [`C_AXI_ADDR_WIDTH-1:0]    M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    output logic [`C_AXI_DATA_WIDTH-1:0]    M_AXI_WDATA,
    output logic [`C_AXI_STROBE_WIDTH-1:0]  M_AXI_WSTRB,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    output logic [`C_AXI_ADDR_WIDTH-1:0]    M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    input  logic [`C_AXI_DATA_WIDTH-1:0]    M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP
);
    localparam int A = `C_AXI_ADDR_WIDTH;
    localparam int D = `C_AXI_DATA_WIDTH;
    localparam int S = `C_AXI_STROBE_WIDTH;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t         state_q, state_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           arvalid_q, arvalid_d;
    logic [A-1:0]   awaddr_q, awaddr_d;
    logic [A-1:0]   araddr_q, araddr_d;
    logic [D-1:0]   wdata_q, wdata_d;
    logic [S-1:0]   wstrb_q, wstrb_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [D-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]     rsp_resp_q, rsp_resp_d;

`ifdef AXI_MST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rsp_timeout_q, rsp_timeout_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXI_MST_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_wr) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                // AW and W retire independently; move on once both are gone
                if (!awvalid_d && !wvalid_d)    state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
`ifdef AXI_MST_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (M_AXI_RVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
`ifdef AXI_MST_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_MST_TIMEOUT_EN
        // A handshake landing on the last allowed cycle still wins
        if (state_q != IDLE && state_d == state_q
            && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            state_d       = IDLE;
        end
        cnt_d = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + CW'(1);
`endif
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
`ifdef AXI_MST_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_MST_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
`ifdef AXI_MST_TIMEOUT_EN
    assign rsp_timeout   = rsp_timeout_q;
`else
    assign rsp_timeout   = 1'b0;
`endif
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = (state_q == RD_RESP);

endmodule

// File: tb/tb_axi_4_mst.sv
// Directed self-checking bench for axi_4_mst.
// Covers reset, write/read orderings, back-to-back issue and mid-flight reset.

`ifndef C_AXI_ADDR_WIDTH
`define C_AXI_ADDR_WIDTH 32
`endif
`ifndef C_AXI_DATA_WIDTH
`define C_AXI_DATA_WIDTH 32
`endif
`ifndef C_AXI_STROBE_WIDTH
`define C_AXI_STROBE_WIDTH 4
`endif

module tb_axi_4_mst;
    localparam int A = `C_AXI_ADDR_WIDTH;
    localparam int D = `C_AXI_DATA_WIDTH;
    localparam int S = `C_AXI_STROBE_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready, cmd_wr;
    logic [A-1:0] cmd_addr;
    logic [D-1:0] cmd_wdata;
    logic [S-1:0] cmd_wstrb;
    logic         rsp_valid, rsp_timeout;
    logic [D-1:0] rsp_rdata;
    logic [1:0]   rsp_resp;
    logic         awvalid, awready, wvalid, wready;
    logic         bvalid, bready, arvalid, arready, rvalid, rready;
    logic [A-1:0] awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic [D-1:0] wdata, rdata;
    logic [S-1:0] wstrb;
    logic [1:0]   bresp, rresp;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    axi_4_mst #(.TIMEOUT_CYCLES(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic idle_slave();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    task automatic issue(input logic wr, input logic [A-1:0] a,
                         input logic [D-1:0] d, input logic [S-1:0] s);
        cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        step();
        cmd_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0;
        idle_slave();
        #23;
        total_cnt++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0)
            $display("FAIL reset_vr: got %b expected 000000",
                     {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        else pass_cnt++;
        total_cnt++;
        if ({awaddr, araddr, wdata, rsp_rdata} !== '0 || rsp_resp !== 2'b00
            || rsp_timeout !== 1'b0 || awprot !== 3'b0 || arprot !== 3'b0)
            $display("FAIL reset_payload: got aw=%h ar=%h w=%h rd=%h rsp=%b",
                     awaddr, araddr, wdata, rsp_rdata, rsp_resp);
        else pass_cnt++;
        rst_n = 1;
        step();
        chk("reset_cmd_ready", cmd_ready, 1);
    endtask

    task automatic test_write_same();
        issue(1, 'h04, 'hDEADBEEF, 'hF);
        chk("wr_awvalid", awvalid, 1);
        chk("wr_wvalid", wvalid, 1);
        chk("wr_awaddr", awaddr, 'h04);
        chk("wr_wdata", wdata, 'hDEADBEEF);
        chk("wr_wstrb", wstrb, 'hF);
        chk("wr_cmd_ready", cmd_ready, 0);
        awready = 1; wready = 1;
        step();
        awready = 0; wready = 0;
        chk("wr_valids_drop", {awvalid, wvalid}, 2'b00);
        chk("wr_bready", bready, 1);
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_resp", rsp_resp, 2'b00);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_bready_off", bready, 0);
        step();
        chk("wr_rsp_pulse", rsp_valid, 0);
    endtask

    task automatic test_write_wlate();
        issue(1, 'h20, 'hCAFEF00D, 'h3);
        awready = 1;
        step();
        awready = 0;
        chk("wl_aw_drop", awvalid, 0);
        chk("wl_w_held", wvalid, 1);
        chk("wl_no_bready", bready, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wl_w_stable", {wvalid, wdata, wstrb}, {1'b1, 32'hCAFEF00D, 4'h3});
            chk("wl_aw_low", awvalid, 0);
        end
        wready = 1;
        step();
        wready = 0;
        chk("wl_w_drop", wvalid, 0);
        chk("wl_bready", bready, 1);
        bvalid = 1; bresp = 2'b01;
        step();
        bvalid = 0;
        chk("wl_rsp", {rsp_valid, rsp_resp}, 3'b101);
        step();
    endtask

    task automatic test_read();
        issue(0, 'h08, 0, 0);
        chk("rd_arvalid", arvalid, 1);
        chk("rd_araddr", araddr, 'h08);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rd_wait", {arvalid, cmd_ready, rready}, 3'b100);
        end
        arready = 1;
        step();
        arready = 0;
        chk("rd_ar_drop", arvalid, 0);
        chk("rd_rready", {rready, cmd_ready}, 2'b10);
        step();
        chk("rd_rwait", {rready, cmd_ready}, 2'b10);
        rvalid = 1; rdata = 'h12345678; rresp = 2'b00;
        step();
        rvalid = 0;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, 'h12345678);
        chk("rd_rresp", rsp_resp, 2'b00);
        step();
        chk("rd_rdata_hold", {rsp_valid, rsp_rdata}, {1'b0, 32'h12345678});
    endtask

    task automatic test_back_to_back();
        issue(0, 'h30, 0, 0);
        arready = 1;
        step();
        arready = 0;
        rvalid = 1; rdata = 'hA5A5A5A5; rresp = 2'b10;
        step();
        rvalid = 0;
        chk("b2b_rsp", {rsp_valid, rsp_resp}, 3'b110);
        chk("b2b_rdata", rsp_rdata, 'hA5A5A5A5);
        chk("b2b_cmd_ready", cmd_ready, 1);
        issue(1, 'h40, 'h11223344, 'hF);
        chk("b2b_wr_accept", {awvalid, wvalid}, 2'b11);
        chk("b2b_awaddr", awaddr, 'h40);
        chk("b2b_resp_hold", {rsp_valid, rsp_resp}, 3'b010);
        awready = 1; wready = 1;
        step();
        awready = 0; wready = 0;
        bvalid = 1;
        bresp = 2'b00;
        step();
        bvalid = 0;
        chk("b2b_wr_rsp", {rsp_valid, rsp_resp, rsp_rdata}, {3'b100, 32'h0});
        step();
    endtask

    task automatic test_reset_mid();
        issue(1, 'h50, 'h55AA55AA, 'hF);
        awready = 1; wready = 1;
        step();
        awready = 0; wready = 0;
        chk("rm_in_wr_resp", bready, 1);
        rst_n = 0;
        bvalid = 1;
        #1;
        chk("rm_async", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rm_cmd_ready", cmd_ready, 1);
        step();
        bvalid = 0;
        #2 rst_n = 1;
        step();
        chk("rm_no_rsp", rsp_valid, 0);
        chk("rm_ready_after", cmd_ready, 1);
        issue(0, 'h0C, 0, 0);
        chk("rm_rd_ar", {arvalid, araddr}, {1'b1, 32'h0C});
        arready = 1;
        step();
        arready = 0;
        rvalid = 1; rdata = 'h0BADF00D; rresp = 2'b00;
        step();
        rvalid = 0;
        chk("rm_rd_done", {rsp_valid, rsp_rdata}, {1'b1, 32'h0BADF00D});
        step();
    endtask

`ifdef AXI_MST_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        bad = 0;
        issue(0, 'h60, 0, 0);
        for (int i = 0; i < 15; i++) begin
            if (arvalid !== 1'b1 || rsp_valid !== 1'b0) bad++;
            step();
        end
        chk("to_waiting", bad, 0);
        chk("to_last_wait", {arvalid, rsp_valid}, 2'b10);
        step();
        chk("to_fire", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1110);
        chk("to_arvalid", arvalid, 0);
        chk("to_idle", cmd_ready, 1);
        step();
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        issue(0, 'h60, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (arvalid !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0)
                bad++;
            step();
        end
        chk("nto_waits", bad, 0);
        arready = 1;
        step();
        arready = 0;
        rvalid = 1; rdata = 'h77; rresp = 2'b01;
        step();
        rvalid = 0;
        chk("nto_done", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1001);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_same();
        test_write_wlate();
        test_read();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_MST_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
